// File: rtl/axi_eth_status_mc.sv
// Per-channel Ethernet status monitor on AXI4-Lite: link state, sticky overrun/drop bits and edge counters.
// Define AXI_ETH_STATUS_IRQ_EN to add the irq output and the irq_mask register at index 31.
module axi_eth_status_mc #(
  parameter int NUM_CHANNELS = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    axi_clk,
  input  logic                    axi_reset,
  input  logic [NUM_CHANNELS-1:0] channel_up,
  input  logic [NUM_CHANNELS-1:0] overrun,
  input  logic [NUM_CHANNELS-1:0] pkt_dropped,
  input  logic [31:0]             S_AXI_AWADDR,
  input  logic                    S_AXI_AWVALID,
  input  logic [2:0]              S_AXI_AWPROT,
  output logic                    S_AXI_AWREADY,
  input  logic [31:0]             S_AXI_WDATA,
  input  logic [3:0]              S_AXI_WSTRB,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic [1:0]              S_AXI_BRESP,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  input  logic [31:0]             S_AXI_ARADDR,
  input  logic                    S_AXI_ARVALID,
  input  logic [2:0]              S_AXI_ARPROT,
  output logic                    S_AXI_ARREADY,
  output logic [31:0]             S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY
`ifdef AXI_ETH_STATUS_IRQ_EN
  ,
  output logic                    irq
`endif
);

  localparam logic [1:0] W_IDLE = 2'd0, W_ACK = 2'd1, W_RESP = 2'd2;
  localparam logic [1:0] R_IDLE = 2'd0, R_ACK = 2'd1, R_DATA = 2'd2;
  localparam logic [1:0] RESP_OKAY = 2'b00, RESP_DECERR = 2'b11;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [4:0] IDX_END = 5'(4 + 2 * NUM_CHANNELS);
  localparam logic [7:0] ID_NCH = 8'(NUM_CHANNELS);
  localparam logic [7:0] ID_CW  = 8'(CNT_WIDTH);

  logic [1:0]              w_state_q, r_state_q;
  logic [1:0]              bresp_q, rresp_q;
  logic [31:0]             rdata_q;
  logic [NUM_CHANNELS-1:0] ovr_prev_q, drp_prev_q;
  logic [NUM_CHANNELS-1:0] ovr_sticky_q, drp_sticky_q;
  logic [NUM_CHANNELS-1:0] ovr_sticky_d, drp_sticky_d;
  logic [CNT_WIDTH-1:0]    ovr_cnt_q [NUM_CHANNELS];
  logic [CNT_WIDTH-1:0]    drp_cnt_q [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] ovr_rise, drp_rise;
  logic [4:0]              wr_idx, rd_idx;
  logic                    wr_hs, rd_hs;
  logic [31:0]             rd_data;
  logic [1:0]              rd_resp;
  logic                    unused_ok;

  // A clear and an edge in the same cycle leave the counter at one.
  function automatic logic [CNT_WIDTH-1:0] cnt_next(input logic [CNT_WIDTH-1:0] cur,
                                                    input logic rise, input logic clr);
    if (clr)
      cnt_next = rise ? CNT_WIDTH'(1) : '0;
    else if (rise && cur != CNT_MAX)
      cnt_next = cur + CNT_WIDTH'(1);
    else
      cnt_next = cur;
  endfunction

  function automatic logic idx_mapped(input logic [4:0] idx);
`ifdef AXI_ETH_STATUS_IRQ_EN
    idx_mapped = (idx < IDX_END) || (idx == 5'd31);
`else
    idx_mapped = (idx < IDX_END);
`endif
  endfunction

  assign ovr_rise = overrun & ~ovr_prev_q;
  assign drp_rise = pkt_dropped & ~drp_prev_q;
  assign wr_idx   = S_AXI_AWADDR[6:2];
  assign rd_idx   = S_AXI_ARADDR[6:2];
  assign wr_hs    = (w_state_q == W_ACK) && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_hs    = (r_state_q == R_ACK) && S_AXI_ARVALID;

  assign ovr_sticky_d = (ovr_sticky_q & ~((wr_hs && wr_idx == 5'd2) ? S_AXI_WDATA[NUM_CHANNELS-1:0] : '0))
                        | ovr_rise;
  assign drp_sticky_d = (drp_sticky_q & ~((wr_hs && wr_idx == 5'd3) ? S_AXI_WDATA[NUM_CHANNELS-1:0] : '0))
                        | drp_rise;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WSTRB, S_AXI_WDATA,
                       S_AXI_AWADDR[31:7], S_AXI_AWADDR[1:0], S_AXI_ARADDR[31:7], S_AXI_ARADDR[1:0]};

  assign S_AXI_AWREADY = (w_state_q == W_ACK);
  assign S_AXI_WREADY  = (w_state_q == W_ACK);
  assign S_AXI_BVALID  = (w_state_q == W_RESP);
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = (r_state_q == R_ACK);
  assign S_AXI_RVALID  = (r_state_q == R_DATA);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

`ifdef AXI_ETH_STATUS_IRQ_EN
  logic [NUM_CHANNELS-1:0] ovr_mask_q, drp_mask_q;
  logic                    irq_q;

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      ovr_mask_q <= '0;
      drp_mask_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      if (wr_hs && wr_idx == 5'd31) begin
        ovr_mask_q <= S_AXI_WDATA[NUM_CHANNELS-1:0];
        drp_mask_q <= S_AXI_WDATA[8 +: NUM_CHANNELS];
      end
      irq_q <= (|(ovr_sticky_q & ovr_mask_q)) | (|(drp_sticky_q & drp_mask_q));
    end
  end
  assign irq = irq_q;
`endif

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (rd_idx)
      5'd0: rd_data = {16'h0, ID_NCH, ID_CW};
      5'd1: rd_data = 32'(channel_up);
      5'd2: rd_data = 32'(ovr_sticky_q);
      5'd3: rd_data = 32'(drp_sticky_q);
`ifdef AXI_ETH_STATUS_IRQ_EN
      5'd31: rd_data = 32'(ovr_mask_q) | (32'(drp_mask_q) << 8);
`endif
      default: begin
        rd_resp = RESP_DECERR;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
          if (rd_idx == 5'(4 + 2 * i)) begin
            rd_data = 32'(ovr_cnt_q[i]);
            rd_resp = RESP_OKAY;
          end
          if (rd_idx == 5'(5 + 2 * i)) begin
            rd_data = 32'(drp_cnt_q[i]);
            rd_resp = RESP_OKAY;
          end
        end
      end
    endcase
  end

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      ovr_prev_q   <= '0;
      drp_prev_q   <= '0;
      ovr_sticky_q <= '0;
      drp_sticky_q <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        ovr_cnt_q[i] <= '0;
        drp_cnt_q[i] <= '0;
      end
    end else begin
      ovr_prev_q   <= overrun;
      drp_prev_q   <= pkt_dropped;
      ovr_sticky_q <= ovr_sticky_d;
      drp_sticky_q <= drp_sticky_d;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        ovr_cnt_q[i] <= cnt_next(ovr_cnt_q[i], ovr_rise[i], wr_hs && wr_idx == 5'(4 + 2 * i));
        drp_cnt_q[i] <= cnt_next(drp_cnt_q[i], drp_rise[i], wr_hs && wr_idx == 5'(5 + 2 * i));
      end
    end
  end

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      w_state_q <= W_IDLE;
      bresp_q   <= RESP_OKAY;
    end else begin
      case (w_state_q)
        W_IDLE: if (S_AXI_AWVALID && S_AXI_WVALID) w_state_q <= W_ACK;
        W_ACK: begin
          if (wr_hs) begin
            bresp_q   <= idx_mapped(wr_idx) ? RESP_OKAY : RESP_DECERR;
            w_state_q <= W_RESP;
          end else begin
            w_state_q <= W_IDLE;
          end
        end
        W_RESP:  if (S_AXI_BREADY) w_state_q <= W_IDLE;
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // Read data is captured at the address handshake and held until RREADY.
  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      r_state_q <= R_IDLE;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (r_state_q)
        R_IDLE: if (S_AXI_ARVALID) r_state_q <= R_ACK;
        R_ACK: begin
          if (rd_hs) begin
            rdata_q   <= rd_data;
            rresp_q   <= rd_resp;
            r_state_q <= R_DATA;
          end else begin
            r_state_q <= R_IDLE;
          end
        end
        R_DATA:  if (S_AXI_RREADY) r_state_q <= R_IDLE;
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_eth_status_mc.sv
// Bench for axi_eth_status_mc: two instances (CNT_WIDTH 16 and 8) share one bus and one set of inputs,
// compared against an event-level model of link status, sticky bits and saturating edge counts.
module tb_axi_eth_status_mc;
  localparam int NC = 2;
  localparam int MAX_A = 65535;
  localparam int MAX_B = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [NC-1:0] chup, ovr, drp;
  logic [31:0]   awaddr, wdata, araddr;
  logic          awvalid, wvalid, arvalid, bready, rready;
  logic [2:0]    prot = 3'b000;
  logic [3:0]    wstrb = 4'hF;

  logic        awready_a, wready_a, bvalid_a, arready_a, rvalid_a;
  logic        awready_b, wready_b, bvalid_b, arready_b, rvalid_b;
  logic [1:0]  bresp_a, rresp_a, bresp_b, rresp_b;
  logic [31:0] rdata_a, rdata_b;
`ifdef AXI_ETH_STATUS_IRQ_EN
  logic        irq_a, irq_b;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model state: raw edge counts since last clear, sticky bits, masks.
  int            m_ocnt [NC];
  int            m_dcnt [NC];
  logic [NC-1:0] m_osticky, m_dsticky, m_omask, m_dmask;

  axi_eth_status_mc #(.NUM_CHANNELS(NC), .CNT_WIDTH(16)) dut_a (
    .axi_clk(clk), .axi_reset(rst), .channel_up(chup), .overrun(ovr), .pkt_dropped(drp),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWPROT(prot), .S_AXI_AWREADY(awready_a),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready_a),
    .S_AXI_BRESP(bresp_a), .S_AXI_BVALID(bvalid_a), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARPROT(prot), .S_AXI_ARREADY(arready_a),
    .S_AXI_RDATA(rdata_a), .S_AXI_RRESP(rresp_a), .S_AXI_RVALID(rvalid_a), .S_AXI_RREADY(rready)
`ifdef AXI_ETH_STATUS_IRQ_EN
    , .irq(irq_a)
`endif
  );

  axi_eth_status_mc #(.NUM_CHANNELS(NC), .CNT_WIDTH(8)) dut_b (
    .axi_clk(clk), .axi_reset(rst), .channel_up(chup), .overrun(ovr), .pkt_dropped(drp),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWPROT(prot), .S_AXI_AWREADY(awready_b),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready_b),
    .S_AXI_BRESP(bresp_b), .S_AXI_BVALID(bvalid_b), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARPROT(prot), .S_AXI_ARREADY(arready_b),
    .S_AXI_RDATA(rdata_b), .S_AXI_RRESP(rresp_b), .S_AXI_RVALID(rvalid_b), .S_AXI_RREADY(rready)
`ifdef AXI_ETH_STATUS_IRQ_EN
    , .irq(irq_b)
`endif
  );

  function automatic int satv(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [1:0] model_resp(input int idx);
`ifdef AXI_ETH_STATUS_IRQ_EN
    if (idx == 31) return 2'b00;
`endif
    return (idx < 4 + 2 * NC) ? 2'b00 : 2'b11;
  endfunction

  function automatic logic [31:0] model_rd(input int idx, input int cw);
    int mx;
    mx = (1 << cw) - 1;
    if (idx == 0) return {16'h0, 8'(NC), 8'(cw)};
    if (idx == 1) return 32'(chup);
    if (idx == 2) return 32'(m_osticky);
    if (idx == 3) return 32'(m_dsticky);
`ifdef AXI_ETH_STATUS_IRQ_EN
    if (idx == 31) return 32'(m_omask) | (32'(m_dmask) << 8);
`endif
    if (idx >= 4 && idx < 4 + 2 * NC) begin
      if ((idx % 2) == 0) return 32'(satv(m_ocnt[(idx - 4) / 2], mx));
      else                return 32'(satv(m_dcnt[(idx - 4) / 2], mx));
    end
    return 32'h0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NC; i++) begin m_ocnt[i] = 0; m_dcnt[i] = 0; end
    m_osticky = '0; m_dsticky = '0; m_omask = '0; m_dmask = '0;
  endtask

  task automatic model_edge(input bit is_drp, input int ch);
    if (is_drp) begin m_dsticky[ch] = 1'b1; m_dcnt[ch]++; end
    else        begin m_osticky[ch] = 1'b1; m_ocnt[ch]++; end
  endtask

  task automatic model_write(input int idx, input logic [31:0] d);
    if (idx == 2) m_osticky &= ~d[NC-1:0];
    if (idx == 3) m_dsticky &= ~d[NC-1:0];
    if (idx >= 4 && idx < 4 + 2 * NC) begin
      if ((idx % 2) == 0) m_ocnt[(idx - 4) / 2] = 0;
      else                m_dcnt[(idx - 4) / 2] = 0;
    end
`ifdef AXI_ETH_STATUS_IRQ_EN
    if (idx == 31) begin m_omask = d[NC-1:0]; m_dmask = d[8 +: NC]; end
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lvl(input bit is_drp, input int ch, input logic v);
    if (is_drp) begin
      if (v && !drp[ch]) model_edge(1'b1, ch);
      drp[ch] = v;
    end else begin
      if (v && !ovr[ch]) model_edge(1'b0, ch);
      ovr[ch] = v;
    end
    tick();
  endtask

  task automatic axi_read(input logic [31:0] addr, input int hold,
                          output logic [31:0] da, output logic [31:0] db,
                          output logic [1:0] ra, output logic [1:0] rb);
    int n;
    n = 0;
    da = '0; db = '0; ra = '0; rb = '0;
    araddr = addr; arvalid = 1'b1;
    while (arready_a !== 1'b1 && n < 20) begin tick(); n++; end
    if (n >= 20) begin
      arvalid = 1'b0; checks++; failures++;
      $display("FAIL rd_handshake arready=%b required 1", arready_a);
      return;
    end
    tick();
    arvalid = 1'b0;
    checks++;
    if (rvalid_a !== 1'b1 || rvalid_b !== 1'b1 || arready_a !== 1'b0) begin
      failures++;
      $display("FAIL rd_latency rvalid=%b/%b arready=%b required 1/1 0", rvalid_a, rvalid_b, arready_a);
    end
    da = rdata_a; db = rdata_b; ra = rresp_a; rb = rresp_b;
    for (int k = 0; k < hold; k++) begin
      tick();
      checks++;
      if (rvalid_a !== 1'b1 || rvalid_b !== 1'b1 || rdata_a !== da || rresp_a !== ra || rdata_b !== db) begin
        failures++;
        $display("FAIL rd_hold cycle %0d rvalid=%b rdata=%h required 1 %h", k, rvalid_a, rdata_a, da);
      end
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    checks++;
    if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0) begin
      failures++;
      $display("FAIL rd_release rvalid=%b/%b required 0/0", rvalid_a, rvalid_b);
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] d, input int hold,
                           input logic [NC-1:0] drp_at_hs,
                           output logic [1:0] ba, output logic [1:0] bb);
    int n;
    n = 0;
    ba = '0; bb = '0;
    awaddr = addr; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
    while (awready_a !== 1'b1 && n < 20) begin tick(); n++; end
    if (n >= 20) begin
      awvalid = 1'b0; wvalid = 1'b0; checks++; failures++;
      $display("FAIL wr_handshake awready=%b required 1", awready_a);
      return;
    end
    checks++;
    if (wready_a !== 1'b1 || awready_b !== 1'b1 || wready_b !== 1'b1) begin
      failures++;
      $display("FAIL wr_ready_pair wready=%b required 1", wready_a);
    end
    drp = drp | drp_at_hs;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    checks++;
    if (bvalid_a !== 1'b1 || bvalid_b !== 1'b1 || awready_a !== 1'b0) begin
      failures++;
      $display("FAIL wr_latency bvalid=%b/%b awready=%b required 1/1 0", bvalid_a, bvalid_b, awready_a);
    end
    ba = bresp_a; bb = bresp_b;
    for (int k = 0; k < hold; k++) begin
      tick();
      checks++;
      if (bvalid_a !== 1'b1 || bresp_a !== ba || bvalid_b !== 1'b1 || bresp_b !== bb) begin
        failures++;
        $display("FAIL wr_hold cycle %0d bvalid=%b bresp=%b required 1 %b", k, bvalid_a, bresp_a, ba);
      end
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    checks++;
    if (bvalid_a !== 1'b0 || bvalid_b !== 1'b0) begin
      failures++;
      $display("FAIL wr_release bvalid=%b/%b required 0/0", bvalid_a, bvalid_b);
    end
  endtask

  task automatic do_reset();
    ovr = '0; drp = '0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    model_clear();
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] da, db;
    logic [1:0]  ra, rb;
    rst = 1'b1;
    tick(); tick(); tick();
    checks++;
    if ({awready_a, wready_a, arready_a, bvalid_a, rvalid_a, bresp_a, rresp_a, rdata_a} !== 39'h0) begin
      failures++;
      $display("FAIL reset_outputs_a got %h required 0", {awready_a, wready_a, arready_a, bvalid_a, rvalid_a, bresp_a, rresp_a, rdata_a});
    end
    checks++;
    if ({awready_b, wready_b, arready_b, bvalid_b, rvalid_b, bresp_b, rresp_b, rdata_b} !== 39'h0) begin
      failures++;
      $display("FAIL reset_outputs_b got %h required 0", {awready_b, wready_b, arready_b, bvalid_b, rvalid_b, bresp_b, rresp_b, rdata_b});
    end
    rst = 1'b0;
    model_clear();
    tick();
    axi_read(32'h0, 0, da, db, ra, rb);
    checks++;
    if (da !== 32'h0000_0210 || ra !== 2'b00) begin
      failures++;
      $display("FAIL id_reg_a got %h/%b required 00000210/00", da, ra);
    end
    checks++;
    if (db !== 32'h0000_0208 || rb !== 2'b00) begin
      failures++;
      $display("FAIL id_reg_b got %h/%b required 00000208/00", db, rb);
    end
  endtask

  task automatic test_reset_edge();
    logic [31:0] da, db;
    logic [1:0]  ra, rb;
    rst = 1'b1; ovr = 2'b01; drp = '0;
    tick(); tick();
    rst = 1'b0;
    model_clear();
    model_edge(1'b0, 0);
    tick(); tick(); tick();
    set_lvl(1'b0, 0, 1'b0);
    axi_read(32'h10, 0, da, db, ra, rb);
    checks++;
    if (da !== model_rd(4, 16) || db !== model_rd(4, 8)) begin
      failures++;
      $display("FAIL reset_release_edge cnt=%h/%h required %h", da, db, model_rd(4, 16));
    end
  endtask

  task automatic test_overrun_sticky();
    logic [31:0] da, db;
    logic [1:0]  ra, rb, ba, bb;
    do_reset();
    for (int p = 0; p < 2; p++) begin
      set_lvl(1'b0, 1, 1'b1);
      tick(); tick(); tick(); tick();
      set_lvl(1'b0, 1, 1'b0);
      tick();
    end
    axi_read(32'h08, 0, da, db, ra, rb);
    checks++;
    if (da !== 32'h2 || da !== model_rd(2, 16) || ra !== 2'b00) begin
      failures++;
      $display("FAIL ovr_sticky got %h/%b required 00000002/00", da, ra);
    end
    axi_read(32'hFFFF_FF18, 0, da, db, ra, rb);
    checks++;
    if (da !== 32'd2 || db !== model_rd(6, 8)) begin
      failures++;
      $display("FAIL ovr_count_ch1 got %h/%h required 00000002", da, db);
    end
    axi_write(32'h08, 32'h2, 0, '0, ba, bb);
    model_write(2, 32'h2);
    checks++;
    if (ba !== 2'b00 || bb !== 2'b00) begin
      failures++;
      $display("FAIL w1c_bresp got %b/%b required 00", ba, bb);
    end
    axi_read(32'h08, 0, da, db, ra, rb);
    checks++;
    if (da !== 32'h0 || db !== 32'h0) begin
      failures++;
      $display("FAIL w1c_clear got %h/%h required 0", da, db);
    end
  endtask

  task automatic test_saturation();
    logic [31:0] da, db;
    logic [1:0]  ra, rb, ba, bb;
    for (int p = 0; p < 300; p++) begin
      set_lvl(1'b1, 0, 1'b1);
      set_lvl(1'b1, 0, 1'b0);
    end
    axi_read(32'h14, 0, da, db, ra, rb);
    checks++;
    if (db !== 32'hFF || db !== model_rd(5, 8)) begin
      failures++;
      $display("FAIL drop_sat_w8 got %h required 000000ff", db);
    end
    checks++;
    if (da !== model_rd(5, 16)) begin
      failures++;
      $display("FAIL drop_count_w16 got %h required %h", da, model_rd(5, 16));
    end
    axi_write(32'h14, 32'hDEAD_BEEF, 0, '0, ba, bb);
    model_write(5, 32'hDEAD_BEEF);
    axi_read(32'h14, 0, da, db, ra, rb);
    checks++;
    if (da !== 32'h0 || db !== 32'h0) begin
      failures++;
      $display("FAIL cnt_write_clear got %h/%h required 0", da, db);
    end
  endtask

  task automatic test_clear_collision();
    logic [31:0] da, db;
    logic [1:0]  ra, rb, ba, bb;
    set_lvl(1'b1, 0, 1'b1);
    set_lvl(1'b1, 0, 1'b0);
    set_lvl(1'b1, 0, 1'b1);
    set_lvl(1'b1, 0, 1'b0);
    axi_write(32'h0C, 32'h1, 0, 2'b01, ba, bb);
    model_write(3, 32'h1);
    model_edge(1'b1, 0);
    set_lvl(1'b1, 0, 1'b0);
    axi_read(32'h0C, 0, da, db, ra, rb);
    checks++;
    if (da[0] !== 1'b1 || da !== model_rd(3, 16)) begin
      failures++;
      $display("FAIL sticky_clear_vs_edge got %h required %h", da, model_rd(3, 16));
    end
    axi_write(32'h14, 32'h0, 0, 2'b01, ba, bb);
    model_write(5, 32'h0);
    model_edge(1'b1, 0);
    set_lvl(1'b1, 0, 1'b0);
    axi_read(32'h14, 0, da, db, ra, rb);
    checks++;
    if (da !== 32'h1 || db !== 32'h1) begin
      failures++;
      $display("FAIL cnt_clear_vs_edge got %h/%h required 1", da, db);
    end
  endtask

  task automatic test_decerr_hold();
    logic [31:0] da, db;
    logic [1:0]  ra, rb, ba, bb;
    axi_read(32'h78, 10, da, db, ra, rb);
    checks++;
    if (ra !== 2'b11 || da !== 32'h0 || rb !== 2'b11 || db !== 32'h0) begin
      failures++;
      $display("FAIL rd_decerr got %h/%b required 0/11", da, ra);
    end
    axi_write(32'h78, 32'hFFFF_FFFF, 10, '0, ba, bb);
    checks++;
    if (ba !== 2'b11 || bb !== 2'b11) begin
      failures++;
      $display("FAIL wr_decerr got %b/%b required 11", ba, bb);
    end
    axi_read(32'h0C, 0, da, db, ra, rb);
    checks++;
    if (da !== model_rd(3, 16)) begin
      failures++;
      $display("FAIL decerr_no_effect got %h required %h", da, model_rd(3, 16));
    end
  endtask

  task automatic test_midflight_reset();
    int n;
    n = 0;
    araddr = 32'h0; arvalid = 1'b1;
    while (arready_a !== 1'b1 && n < 20) begin tick(); n++; end
    tick();
    arvalid = 1'b0;
    rst = 1'b1;
    tick();
    checks++;
    if (rvalid_a !== 1'b0 || rdata_a !== 32'h0 || rvalid_b !== 1'b0) begin
      failures++;
      $display("FAIL reset_abandon_read rvalid=%b rdata=%h required 0 0", rvalid_a, rdata_a);
    end
    rst = 1'b0;
    tick();
    n = 0;
    awaddr = 32'h0; wdata = 32'h0; awvalid = 1'b1; wvalid = 1'b1;
    while (awready_a !== 1'b1 && n < 20) begin tick(); n++; end
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    rst = 1'b1;
    tick();
    checks++;
    if (bvalid_a !== 1'b0 || bvalid_b !== 1'b0 || bresp_a !== 2'b00) begin
      failures++;
      $display("FAIL reset_abandon_write bvalid=%b required 0", bvalid_a);
    end
    rst = 1'b0;
    model_clear();
    tick();
  endtask

`ifdef AXI_ETH_STATUS_IRQ_EN
  task automatic test_irq();
    logic [1:0] ba, bb;
    do_reset();
    axi_write(32'h7C, 32'h1, 0, '0, ba, bb);
    model_write(31, 32'h1);
    set_lvl(1'b0, 0, 1'b1);
    checks++;
    if (irq_a !== 1'b0) begin
      failures++;
      $display("FAIL irq_registered got %b required 0", irq_a);
    end
    tick();
    checks++;
    if (irq_a !== 1'b1 || irq_b !== 1'b1) begin
      failures++;
      $display("FAIL irq_assert got %b/%b required 1", irq_a, irq_b);
    end
    set_lvl(1'b0, 0, 1'b0);
    axi_write(32'h08, 32'h1, 0, '0, ba, bb);
    model_write(2, 32'h1);
    tick();
    checks++;
    if (irq_a !== 1'b0 || irq_b !== 1'b0) begin
      failures++;
      $display("FAIL irq_clear got %b/%b required 0", irq_a, irq_b);
    end
  endtask
`endif

  task automatic test_random();
    logic [31:0] da, db, d, addr;
    logic [1:0]  ra, rb, ba, bb;
    int idx, ch;
    bit sel;
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(3))
        0: begin
          sel = 1'($urandom_range(1));
          ch  = $urandom_range(NC - 1);
          set_lvl(sel, ch, sel ? ~drp[ch] : ~ovr[ch]);
        end
        1: begin
          idx  = $urandom_range(31);
          addr = {25'($urandom), 5'(idx), 2'($urandom)};
          axi_read(addr, $urandom_range(2), da, db, ra, rb);
          checks++;
          if (da !== model_rd(idx, 16) || db !== model_rd(idx, 8) ||
              ra !== model_resp(idx) || rb !== model_resp(idx)) begin
            failures++;
            $display("FAIL rand_read idx=%0d got %h/%h/%b required %h/%h/%b", idx, da, db, ra,
                     model_rd(idx, 16), model_rd(idx, 8), model_resp(idx));
          end
        end
        2: begin
          idx  = $urandom_range(31);
          addr = {25'($urandom), 5'(idx), 2'($urandom)};
          d    = $urandom;
          axi_write(addr, d, $urandom_range(2), '0, ba, bb);
          model_write(idx, d);
          checks++;
          if (ba !== model_resp(idx) || bb !== model_resp(idx)) begin
            failures++;
            $display("FAIL rand_write idx=%0d got %b/%b required %b", idx, ba, bb, model_resp(idx));
          end
        end
        default: begin
          chup = NC'($urandom);
          tick();
        end
      endcase
`ifdef AXI_ETH_STATUS_IRQ_EN
      tick();
      checks++;
      if (irq_a !== ((|(m_osticky & m_omask)) | (|(m_dsticky & m_dmask)))) begin
        failures++;
        $display("FAIL rand_irq got %b required %b", irq_a, (|(m_osticky & m_omask)) | (|(m_dsticky & m_dmask)));
      end
`endif
    end
  endtask

  initial begin
    rst = 1'b1; chup = 2'b10; ovr = '0; drp = '0;
    awaddr = '0; wdata = '0; araddr = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    model_clear();
    test_reset();
    test_overrun_sticky();
    test_saturation();
    test_clear_collision();
    test_decerr_hold();
    test_reset_edge();
    test_midflight_reset();
`ifdef AXI_ETH_STATUS_IRQ_EN
    test_irq();
`endif
    do_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
